// File: rtl/dit_pkg.sv
// Shared constants and the bit-reversal helper for the ping-pong DIT input store.
package dit_pkg;

    localparam int DATA_W_DEF = 12;
    localparam int N_LOG2_DEF = 4;
    localparam int N_LOG2_MAX = 10;
    localparam int OVR_W      = 8;

    localparam logic [OVR_W-1:0] OVR_MAX = '1;

    // Reverses the low 'width' bits of v; bits above 'width' come back as zero.
    function automatic logic [N_LOG2_MAX-1:0] bitrev(
        input logic [N_LOG2_MAX-1:0] v,
        input int                    width
    );
        logic [N_LOG2_MAX-1:0] r;
        logic [N_LOG2_MAX-1:0] s;
        r = '0;
        s = v;
        for (int i = 0; i < N_LOG2_MAX; i++) begin
            if (i < width) begin
                r = {r[N_LOG2_MAX-2:0], s[0]};
                s = s >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dit_bank_ram.sv
// Two-bank sample storage addressed as {bank, addr}: one write port, one read
// port with a registered (enabled) output.
module dit_bank_ram #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              re,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_reg;

    // Array contents are never reset so the storage maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Output register holds its value between enabled reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_reg <= '0;
        end else if (re) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/dit_pingpong_store.sv
// Ping-pong input store for a DIT FFT: samples are written bit-reversed into
// alternating banks while the FFT reads the other bank in natural order.
module dit_pingpong_store
    import dit_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N_LOG2 = N_LOG2_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              frame_rdy,
    input  logic              rd_req,
    input  logic [N_LOG2-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              frame_done,
    output logic [OVR_W-1:0]  overrun_cnt
);

    localparam logic [N_LOG2-1:0] LAST_IDX = '1;

    logic [1:0]        full_reg, full_next;
    logic              wr_bank_reg, wr_bank_next;
    logic              rd_bank_reg, rd_bank_next;
    logic [N_LOG2-1:0] wr_cnt_reg, wr_cnt_next;
    logic [OVR_W-1:0]  overrun_reg, overrun_next;
    logic              rd_valid_reg;

    logic              accept;
    logic              drop;
    logic              complete;
    logic              release_bank;
    logic              rd_fire;
    logic [N_LOG2-1:0] wr_addr_rev;

    // Handshake status depends only on registered flags, never on the inputs.
    assign in_ready  = !full_reg[wr_bank_reg];
    assign frame_rdy = full_reg[rd_bank_reg];

    assign accept       = in_valid && in_ready;
    assign drop         = in_valid && !in_ready;
    assign complete     = accept && (wr_cnt_reg == LAST_IDX);
    assign release_bank = frame_done && frame_rdy;
    assign rd_fire      = rd_req && frame_rdy;

    assign wr_addr_rev = N_LOG2'(bitrev(N_LOG2_MAX'(wr_cnt_reg), N_LOG2));

    always_comb begin
        full_next    = full_reg;
        wr_bank_next = wr_bank_reg;
        rd_bank_next = rd_bank_reg;
        wr_cnt_next  = wr_cnt_reg;
        overrun_next = overrun_reg;

        // A release always targets a full bank and a completion an empty one,
        // so both can land in the same cycle without interfering.
        if (release_bank) begin
            full_next[rd_bank_reg] = 1'b0;
            rd_bank_next           = !rd_bank_reg;
        end

        if (accept) begin
            wr_cnt_next = wr_cnt_reg + 1'b1;
            if (complete) begin
                full_next[wr_bank_reg] = 1'b1;
                wr_bank_next           = !wr_bank_reg;
            end
        end

        if (drop && (overrun_reg != OVR_MAX)) begin
            overrun_next = overrun_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_reg     <= '0;
            wr_bank_reg  <= 1'b0;
            rd_bank_reg  <= 1'b0;
            wr_cnt_reg   <= '0;
            overrun_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            full_reg     <= full_next;
            wr_bank_reg  <= wr_bank_next;
            rd_bank_reg  <= rd_bank_next;
            wr_cnt_reg   <= wr_cnt_next;
            overrun_reg  <= overrun_next;
            rd_valid_reg <= rd_fire;
        end
    end

    dit_bank_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (N_LOG2 + 1)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (accept),
        .wr_addr ({wr_bank_reg, wr_addr_rev}),
        .wr_data (in_data),
        .re      (rd_fire),
        .rd_addr ({rd_bank_reg, rd_addr}),
        .rd_data (rd_data)
    );

    assign rd_valid    = rd_valid_reg;
    assign overrun_cnt = overrun_reg;

endmodule

// File: doc/dit_pingpong_store.md
# dit_pingpong_store

Parametrised, clocked successor to the FFT input sample store: accepts ADC samples over a valid/ready handshake and writes them into one of two banks in bit-reversed order, so the decimation-in-time FFT reads its inputs in natural address order. Ping-pong banking lets the ADC fill one frame while the FFT reads the other, so the store no longer drops samples while waiting on the FFT. The block sits between the ADC capture logic and the FFT core; any remaining drops are counted.

## Interface
Parameters:
- `DATA_W`, 12: sample width in bits.
- `N_LOG2`, 4: log2 of frame length; N = 2**N_LOG2 samples per frame, legal range 2..10.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  ADC sample present on `in_data`.
- `in_data`  in  DATA_W  ADC sample.
- `in_ready`  out  1  store can accept a sample this cycle.
- `frame_rdy`  out  1  a complete frame is available for reading.
- `rd_req`  in  1  read request.
- `rd_addr`  in  N_LOG2  natural-order FFT input index.
- `rd_data`  out  DATA_W  registered read data.
- `rd_valid`  out  1  `rd_data` is valid this cycle.
- `frame_done`  in  1  single-cycle pulse: FFT has finished with the current read bank.
- `overrun_cnt`  out  8  dropped-sample count, saturating.

## Operation
- State: `full[1:0]`, `wr_bank`, `rd_bank`, `wr_cnt` (N_LOG2 bits), `overrun_cnt`.
- Reset values: all state 0; outputs `in_ready`=1, `frame_rdy`=0, `rd_valid`=0, `rd_data`=0, `overrun_cnt`=0. RAM contents are not reset.
- Accept: when `in_valid && in_ready`, the block writes `in_data` to bank `wr_bank`, address `bitrev(wr_cnt)`, then increments `wr_cnt`.
- Frame completion: on an accepted write with `wr_cnt == N-1`, the block sets `full[wr_bank]`, toggles `wr_bank`, and wraps `wr_cnt` to 0.
- `in_ready = !full[wr_bank]`. This is combinational from registers, with no dependence on `in_valid`.
- Drop: when `in_valid && !in_ready`, the sample is discarded and `overrun_cnt` increments, saturating at 255. `wr_cnt` is unchanged. Only reset clears the counter.
- `frame_rdy = full[rd_bank]`.
- Read: when `rd_req && frame_rdy`, the block latches bank `rd_bank`, address `rd_addr`, into `rd_data`. A read at address k returns the sample that arrived with index bitrev(k).
- A `rd_req` while `frame_rdy` is 0 is ignored: `rd_valid` stays 0 and `rd_data` holds its value.
- Release: `frame_done && frame_rdy` clears `full[rd_bank]` and toggles `rd_bank`. A `frame_done` while `frame_rdy` is 0 is ignored.
- Simultaneous events:
  - A completing write on one bank and `frame_done` on the other bank in the same cycle both take effect.
  - A `rd_req` in the same cycle as `frame_done` still reads the old bank.
- Both banks full: `in_ready` is 0 until the first `frame_done`.
- Reset mid-frame discards any partial frame and all full banks.

## Timing
- Write: zero-latency acceptance. A sample accepted at edge t is readable once `frame_rdy` is observed.
- `frame_rdy` rises in the cycle after the edge that accepts sample N-1, provided the read bank was empty.
- Read latency is 1 cycle: `rd_req` sampled at edge t gives `rd_data` and `rd_valid` valid after edge t. `rd_valid` is a one-cycle pulse per request.
- Reads may be issued back-to-back, one per cycle.
- `in_ready` falls in the cycle after the frame-completing write when the other bank is full. It rises in the cycle after the freeing `frame_done`.
- There is no combinational path from `in_valid` to `in_ready`, or from `rd_req` to `rd_data`.

## Structure
- Package `dit_pkg`:
  - default `DATA_W` and `N_LOG2` constants;
  - `bitrev` function, parametrised by width;
  - 8-bit overrun counter width constant.
- Sub-module `dit_bank_ram`: 2×N×DATA_W storage with one write port, one read port and registered read output. Addressing is {bank, addr}.
- Top level holds the control flags, counters and handshake logic.

## Test plan
- Reset, then 16 samples with values 0..15 and `in_valid` held high. `frame_rdy` rises 1 cycle after the 16th accept. Reading addresses 0..15 returns 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15, each with `rd_valid` 1 cycle after its request.
- Stream 48 samples continuously with no `frame_done`. Samples 0..31 are accepted, `in_ready` drops after the 32nd, and `overrun_cnt` reaches 16.
- Same fill as the previous test, then pulse `frame_done`. `in_ready` rises the next cycle. Reads now return frame 2 (values 16..31, bit-reversed). The next 16 samples fill bank 0.
- Complete the last write of bank 1 in the same cycle as `frame_done` on bank 0. `frame_rdy` stays 1 (now bank 1) and `in_ready` stays 1.
- Hold `in_valid` high with both banks full for 300 cycles: `overrun_cnt` saturates at 255.
- Assert `rst_n` low after 7 accepted samples: all outputs return to their reset values. The next 16 samples form a clean frame starting at index 0.
- Pulse `rd_req` and `frame_done` while `frame_rdy` is 0: no `rd_valid`, and state is unchanged.
